shift_pattern_engine: RTL
=========================

// Module: shift_pattern_engine
//
// PURPOSE
//   Parametrised LED pattern shift engine. It generalises the single-mode,
//   fixed-width, fixed-rate shift register used for board LED demos.
//   Features: configurable width and step rate, four modes (serial shift,
//   rotate, bounce, hold), selectable direction, parallel load and clear.
//   It sits between the user keys/switches and the LED or 7-segment drivers.
//   q is active-high; the top level inverts it for active-low LEDs.
//
// PARAMETERS
//   WIDTH  12  pattern register width in bits; legal range WIDTH >= 2
//   DIV_W  23  prescaler width; one step every 2**DIV_W enabled clocks
//
// PORTS
//   clk         in   1      system clock
//   reset       in   1      synchronous reset, active-high
//   run         in   1      1 = prescaler counts; 0 = freeze prescaler and q
//   mode        in   2      00 SHIFT, 01 ROTATE, 10 BOUNCE, 11 HOLD
//   dir         in   1      0 = right (toward bit 0), 1 = left (toward MSB)
//   serial_in   in   1      fill bit for SHIFT mode
//   load        in   1      1-cycle pulse: q <= load_value
//   load_value  in   WIDTH  parallel load data
//   clear       in   1      1-cycle pulse: q, prescaler <= 0
//   q           out  WIDTH  pattern register
//   tick        out  1      step strobe (combinational)
//   bdir        out  1      current bounce direction, same encoding as dir
//
// BEHAVIOUR
//   Reset (sync, active-high, highest priority)
//     - next clk edge: q=0, cnt=0, bdir=0; tick therefore 0.
//     - Reset mid-step discards that step.
//   Prescaler
//     - cnt[DIV_W-1:0] increments each clk while run=1 and wraps to 0.
//     - run=0 holds cnt.
//     - tick = run & (cnt == 2**DIV_W-1), i.e. one pulse per 2**DIV_W
//       run cycles.
//   Priority per edge: reset > clear > load > tick step > hold.
//   clear
//     - q=0, cnt=0, bdir<=dir.
//     - A coincident load or tick is ignored.
//   load
//     - q=load_value, bdir<=dir; cnt keeps counting.
//     - A coincident tick step is dropped; cnt still wraps.
//   Step on tick, 1-cycle latency (q updates on the edge where tick=1):
//     - SHIFT   dir=0: q <= {serial_in, q[W-1:1]}
//               dir=1: q <= {q[W-2:0], serial_in}
//     - ROTATE  dir=0: q <= {q[0], q[W-1:1]}
//               dir=1: q <= {q[W-2:0], q[W-1]}
//     - BOUNCE  zero-fill shift in bdir; a set bit is never lost:
//         bdir=0 & q[0]=1    -> bdir<=1, shift left this tick
//         bdir=1 & q[W-1]=1  -> bdir<=0, shift right this tick
//         q[0]=1 & q[W-1]=1  -> q and bdir held (no legal move)
//         q=0                -> q stays 0, bdir unchanged
//     - HOLD: q unchanged; tick still pulses.
//   Mode/direction rules
//     - mode and dir are sampled only on tick edges.
//     - Changing mode mid-period does not reset cnt.
//     - bdir changes only by clear, load or a BOUNCE flip.
//   All outputs are registered except tick.
//
// TESTING (WIDTH=12, DIV_W=2, i.e. tick every 4 run cycles)
//   1. SHIFT, dir=0, serial_in=1, run=1 from q=0, 4 ticks
//      -> q=12'hF00; each change exactly on a tick edge.
//   2. ROTATE, dir=1, load 12'h801, one tick -> q=12'h003;
//      dir=0 from 12'h801 -> 12'hC00.
//   3. BOUNCE, load 12'h001 with dir=0:
//      - tick 1: q=12'h002, bdir=1
//      - 10 more ticks: q=12'h800
//      - next tick: q=12'h400, bdir=0
//   4. load 12'h0F0 and clear on the same tick edge -> q=0, cnt=0.
//      load alone on a tick edge -> q=12'h0F0, no shift.
//   5. run=0 for 10 cycles: q and cnt frozen, tick=0.
//      reset asserted mid-period -> q=0, cnt=0, bdir=0 next edge.
//   6. HOLD: tick pulses, q unchanged.
//      BOUNCE with q=12'h801: q and bdir held for 3 ticks.

Source files
------------

// File: rtl/shift_pattern_engine.sv
// LED pattern shift engine: prescaled step strobe driving shift, rotate,
// bounce or hold on a WIDTH-bit pattern register, with parallel load and clear.
module shift_pattern_engine #(
  parameter int WIDTH = 12,
  parameter int DIV_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             serial_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             bdir
);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] q_step;
  logic             bdir_step;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign tick     = run && (cnt == {DIV_W{1'b1}});

  always_comb begin
    q_step    = q;
    bdir_step = bdir;
    case (mode_sel)
      MODE_SHIFT:
        q_step = dir ? {q[WIDTH-2:0], serial_in} : {serial_in, q[WIDTH-1:1]};
      MODE_ROTATE:
        q_step = dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
      MODE_BOUNCE: begin
        // An empty pattern or one pinned at both ends has no legal move.
        if ((q != '0) && !(q[0] && q[WIDTH-1])) begin
          if (!bdir && q[0]) begin
            bdir_step = 1'b1;
            q_step    = {q[WIDTH-2:0], 1'b0};
          end else if (bdir && q[WIDTH-1]) begin
            bdir_step = 1'b0;
            q_step    = {1'b0, q[WIDTH-1:1]};
          end else if (bdir) begin
            q_step = {q[WIDTH-2:0], 1'b0};
          end else begin
            q_step = {1'b0, q[WIDTH-1:1]};
          end
        end
      end
      MODE_HOLD: q_step = q;
      default:   q_step = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      cnt  <= '0;
      bdir <= 1'b0;
    end else if (clear) begin
      q    <= '0;
      cnt  <= '0;
      bdir <= dir;
    end else begin
      if (run) cnt <= cnt + 1'b1;
      // A load on a tick edge swallows that step; the prescaler still wraps.
      if (load) begin
        q    <= load_value;
        bdir <= dir;
      end else if (tick) begin
        q    <= q_step;
        bdir <= bdir_step;
      end
    end
  end

endmodule
